adc_ddr_capture_mc: RTL and testbench

Multi-channel, parametrised successor to the single-ADC DDR capture stage. It takes per-channel word pairs already split by the IDDR primitives into rising-edge and falling-edge words, all in the DCO clock domain. It registers and optionally reorders each pair, then emits q1/q2 sample pairs with a valid flag. Per channel it runs a training-pattern checker (fixed pattern or ramp) with a lock state machine and an error counter, so firmware can confirm link alignment before using data.

---
 rtl/adc_ddr_capture_mc.sv | 180 ++++++++++++++++++
 tb/tb_adc_ddr_capture_mc.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ddr_capture_mc.sv
// Multi-channel ADC DDR capture: registered rise/fall pairing with
// per-channel training-pattern lock tracking and error counting.
module adc_ddr_capture_mc #(
  parameter int                N_CH     = 2,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] PAT_A    = 16'hE5E3,
  parameter logic [DATA_W-1:0] PAT_B    = 16'h1A1C,
  parameter int                LOCK_CNT = 16,
  parameter int                MISS_MAX = 4,
  parameter int                ERR_W    = 16
) (
  input  logic                   AdcDCO_i,
  input  logic                   Rst_i,
  input  logic [N_CH*DATA_W-1:0] Rise_i,
  input  logic [N_CH*DATA_W-1:0] Fall_i,
  input  logic                   InVld_i,
  input  logic [1:0]             Mode_i,
  input  logic [N_CH-1:0]        Swap_i,
  input  logic                   ClrErr_i,
  output logic [N_CH*DATA_W-1:0] q1_o,
  output logic [N_CH*DATA_W-1:0] q2_o,
  output logic                   OutVld_o,
  output logic [N_CH-1:0]        Lock_o,
  output logic [N_CH*ERR_W-1:0]  ErrCnt_o
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  logic [N_CH*DATA_W-1:0] rise_r;
  logic [N_CH*DATA_W-1:0] fall_r;
  logic                   vld_r;
  logic                   out_vld;
  logic [1:0]             mode_r;
  logic                   mode_act;
  logic                   mode_chg;

  assign mode_act = (Mode_i == 2'b01) || (Mode_i == 2'b10);
  assign mode_chg = (Mode_i != mode_r);
  assign OutVld_o = out_vld;

  always_ff @(posedge AdcDCO_i) begin
    if (Rst_i) begin
      rise_r  <= '0;
      fall_r  <= '0;
      vld_r   <= 1'b0;
      out_vld <= 1'b0;
      mode_r  <= Mode_i;
    end else begin
      rise_r  <= Rise_i;
      fall_r  <= Fall_i;
      vld_r   <= InVld_i;
      out_vld <= vld_r;
      mode_r  <= Mode_i;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0] rise_w;
    logic [DATA_W-1:0] fall_w;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;
    logic [DATA_W-1:0] prev;
    logic              swap_r;
    logic              seed;
    logic              lock;
    logic              pat_ok;
    logic              ramp_ok;
    logic              match;
    logic              chg;
    logic              bump;
    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;
    logic [ERR_W-1:0]  err;

    assign rise_w  = rise_r[c*DATA_W +: DATA_W];
    assign fall_w  = fall_r[c*DATA_W +: DATA_W];
    assign pat_ok  = (q1 == PAT_A) && (q2 == PAT_B);
    assign ramp_ok = (q2 == q1 + ONE) &&
                     (!seed || (q1 == prev + ONE));
    assign match   = (Mode_i == 2'b01) ? pat_ok : ramp_ok;
    assign chg     = mode_chg || (Swap_i[c] != swap_r);
    assign bump    = mode_act && !chg && out_vld && !match &&
                     (state != HUNT) && (err != '1);

    always_ff @(posedge AdcDCO_i) begin
      if (Rst_i) begin
        q1 <= '0;
        q2 <= '0;
      end else if (vld_r) begin
        q1 <= Swap_i[c] ? fall_w : rise_w;
        q2 <= Swap_i[c] ? rise_w : fall_w;
      end
    end

    // Checker consumes the registered output pair, one edge after it appears.
    always_ff @(posedge AdcDCO_i) begin
      if (Rst_i) begin
        state  <= HUNT;
        run    <= '0;
        miss   <= '0;
        seed   <= 1'b0;
        prev   <= '0;
        lock   <= 1'b0;
        swap_r <= Swap_i[c];
      end else begin
        swap_r <= Swap_i[c];
        if (!mode_act || chg) begin
          state <= HUNT;
          run   <= '0;
          miss  <= '0;
          seed  <= 1'b0;
          lock  <= 1'b0;
        end else if (out_vld) begin
          seed <= 1'b1;
          prev <= q2;
          unique case (state)
            HUNT: begin
              if (match) begin
                state <= CHECK;
                run   <= RUN_W'(1);
              end
            end
            CHECK: begin
              if (match) begin
                run <= run + RUN_W'(1);
                if (run == RUN_LAST) begin
                  state <= LOCKED;
                  lock  <= 1'b1;
                  miss  <= '0;
                end
              end else begin
                state <= HUNT;
                run   <= '0;
                seed  <= 1'b0;
              end
            end
            LOCKED: begin
              if (match) begin
                miss <= '0;
              end else if (miss == MISS_LAST) begin
                state <= HUNT;
                lock  <= 1'b0;
                run   <= '0;
                miss  <= '0;
                seed  <= 1'b0;
              end else begin
                miss <= miss + MISS_W'(1);
              end
            end
            default: begin
              state <= HUNT;
              lock  <= 1'b0;
            end
          endcase
        end
      end
    end

    always_ff @(posedge AdcDCO_i) begin
      if (Rst_i || ClrErr_i) begin
        err <= '0;
      end else if (bump) begin
        err <= err + ERR_W'(1);
      end
    end

    assign q1_o[c*DATA_W +: DATA_W]  = q1;
    assign q2_o[c*DATA_W +: DATA_W]  = q2;
    assign Lock_o[c]                 = lock;
    assign ErrCnt_o[c*ERR_W +: ERR_W] = err;
  end

endmodule

// File: tb/tb_adc_ddr_capture_mc.sv
// Scoreboard bench for adc_ddr_capture_mc: randomized beats against a
// beat-level behavioural model of pairing, lock and error counting.
`timescale 1ns/1ps
module tb_adc_ddr_capture_mc;
  localparam int N     = 2;
  localparam int DW    = 16;
  localparam int EW    = 4;
  localparam int LOCKN = 16;
  localparam int MISSN = 4;
  localparam logic [15:0] PA = 16'hE5E3;
  localparam logic [15:0] PB = 16'h1A1C;

  logic          clk = 1'b0;
  logic          Rst_i = 1'b1;
  logic [31:0]   Rise_i = '0;
  logic [31:0]   Fall_i = '0;
  logic          InVld_i = 1'b0;
  logic [1:0]    Mode_i = 2'b00;
  logic [1:0]    Swap_i = 2'b00;
  logic          ClrErr_i = 1'b0;
  logic [31:0]   q1_o;
  logic [31:0]   q2_o;
  logic          OutVld_o;
  logic [1:0]    Lock_o;
  logic [7:0]    ErrCnt_o;

  adc_ddr_capture_mc #(.ERR_W(EW)) dut (
    .AdcDCO_i(clk), .Rst_i(Rst_i), .Rise_i(Rise_i),
    .Fall_i(Fall_i), .InVld_i(InVld_i), .Mode_i(Mode_i),
    .Swap_i(Swap_i), .ClrErr_i(ClrErr_i), .q1_o(q1_o),
    .q2_o(q2_o), .OutVld_o(OutVld_o), .Lock_o(Lock_o),
    .ErrCnt_o(ErrCnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q1;
    logic [31:0] q2;
    logic [1:0]  lock;
    logic [7:0]  err;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  // model state: matches in a row, misses in a row, locked flag
  int          run_m[N];
  int          miss_m[N];
  int          err_m[N];
  bit          lock_m[N];
  bit          seed_m[N];
  logic [15:0] prev_m[N];
  logic [15:0] base[N];
  logic [31:0] last_q1 = '0;
  bit          clr_h0 = 1'b0;
  bit          clr_h1 = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hunt_ch(input int c);
    run_m[c] = 0;
    miss_m[c] = 0;
    lock_m[c] = 1'b0;
    seed_m[c] = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      hunt_ch(c);
      err_m[c] = 0;
    end
    last_q1 = '0;
  endtask

  task automatic model_beat(input logic [31:0] r,
                            input logic [31:0] f,
                            input bit clr);
    exp_t e;
    logic [15:0] a;
    logic [15:0] b;
    bit act;
    bit m;
    bit counted;
    bit drop;
    act = (Mode_i == 2'b01) || (Mode_i == 2'b10);
    for (int c = 0; c < N; c++) begin
      a = Swap_i[c] ? f[c*16 +: 16] : r[c*16 +: 16];
      b = Swap_i[c] ? r[c*16 +: 16] : f[c*16 +: 16];
      e.q1[c*16 +: 16] = a;
      e.q2[c*16 +: 16] = b;
      if (act) begin
        if (Mode_i == 2'b01)
          m = (a == PA) && (b == PB);
        else
          m = (b == 16'(a + 1)) &&
              (!seed_m[c] || a == 16'(prev_m[c] + 1));
        counted = !m && (lock_m[c] || run_m[c] > 0);
        drop = 1'b0;
        if (!lock_m[c]) begin
          if (m) begin
            run_m[c]++;
            if (run_m[c] == LOCKN) begin
              lock_m[c] = 1'b1;
              miss_m[c] = 0;
            end
          end else begin
            drop = run_m[c] > 0;
            run_m[c] = 0;
          end
        end else if (m) begin
          miss_m[c] = 0;
        end else begin
          miss_m[c]++;
          if (miss_m[c] == MISSN) begin
            hunt_ch(c);
            drop = 1'b1;
          end
        end
        seed_m[c] = !drop;
        prev_m[c] = b;
        if (counted && err_m[c] < (1 << EW) - 1) err_m[c]++;
      end
      if (clr) err_m[c] = 0;
      e.lock[c] = lock_m[c];
      e.err[c*EW +: EW] = EW'(err_m[c]);
    end
    last_q1 = e.q1;
    sb.push_back(e);
  endtask

  // ClrErr is delayed so it lands on the edge that checks its beat
  task automatic beat(input logic [31:0] r, input logic [31:0] f,
                      input bit v, input bit clr);
    @(negedge clk);
    Rise_i = r;
    Fall_i = f;
    InVld_i = v;
    ClrErr_i = clr_h1;
    clr_h1 = clr_h0;
    clr_h0 = v && clr;
    if (v) model_beat(r, f, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat($urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    idle(4);
    if (m != Mode_i)
      for (int c = 0; c < N; c++) hunt_ch(c);
    Mode_i = m;
  endtask

  task automatic set_swap(input logic [1:0] s);
    idle(4);
    for (int c = 0; c < N; c++)
      if (s[c] != Swap_i[c]) hunt_ch(c);
    Swap_i = s;
  endtask

  task automatic gen_ch(input int c, input bit bad,
                        output logic [15:0] r, output logic [15:0] f);
    logic [15:0] a;
    logic [15:0] b;
    case (Mode_i)
      2'b01: begin
        a = bad ? 16'($urandom) : PA;
        b = PB;
      end
      2'b10: begin
        if (bad) base[c] = base[c] + 16'(2 + $urandom_range(5));
        a = base[c];
        b = a + 16'd1;
        base[c] = base[c] + 16'd2;
      end
      default: begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
    endcase
    r = Swap_i[c] ? b : a;
    f = Swap_i[c] ? a : b;
  endtask

  task automatic gen_beat(input logic [1:0] bad, input bit clr);
    logic [31:0] r;
    logic [31:0] f;
    logic [15:0] rc;
    logic [15:0] fc;
    for (int c = 0; c < N; c++) begin
      gen_ch(c, bad[c], rc, fc);
      r[c*16 +: 16] = rc;
      f[c*16 +: 16] = fc;
    end
    beat(r, f, 1'b1, clr);
  endtask

  task automatic do_reset();
    idle(4);
    @(negedge clk);
    Rst_i = 1'b1;
    InVld_i = 1'b0;
    ClrErr_i = 1'b0;
    clr_h0 = 1'b0;
    clr_h1 = 1'b0;
    @(negedge clk);
    Rst_i = 1'b0;
    model_reset();
  endtask

  exp_t pend_e;
  bit   pend = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      check("lock", Lock_o, pend_e.lock);
      check("errcnt", ErrCnt_o, pend_e.err);
      pend = 1'b0;
    end
    if (OutVld_o) begin
      if (sb.size() == 0) begin
        check("beat_queue", sb.size(), 1);
      end else begin
        pend_e = sb.pop_front();
        check("q1", q1_o, pend_e.q1);
        check("q2", q2_o, pend_e.q2);
        pend = 1'b1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pr;
    logic [31:0] pf;
    logic [31:0] bad1;
    pr = {PA, PA};
    pf = {PB, PB};
    bad1 = {16'hE5E2, PA};
    model_reset();
    repeat (2) @(negedge clk);
    Rst_i = 1'b0;
    idle(3);
    check("rst_q1", q1_o, 0);
    check("rst_q2", q2_o, 0);
    check("rst_vld", OutVld_o, 0);
    check("rst_lock", Lock_o, 0);
    check("rst_err", ErrCnt_o, 0);

    set_mode(2'b01);
    beat(pr, pf, 1'b1, 1'b0);
    beat(pr, pf, 1'b1, 1'b0);
    check("latency_pre", OutVld_o, 0);
    beat(pr, pf, 1'b1, 1'b0);
    check("latency", OutVld_o, 1);
    repeat (17) beat(pr, pf, 1'b1, 1'b0);
    idle(4);
    check("pat_lock", Lock_o, 2'b11);
    check("pat_err", ErrCnt_o, 0);

    beat(bad1, pf, 1'b1, 1'b0);
    idle(4);
    check("one_bad_lock", Lock_o, 2'b11);
    check("one_bad_err", ErrCnt_o, 8'h10);
    repeat (2) beat(pr, pf, 1'b1, 1'b0);
    repeat (4) beat(bad1, pf, 1'b1, 1'b0);
    idle(4);
    check("drop_lock", Lock_o, 2'b01);
    check("drop_err", ErrCnt_o, 8'h50);

    set_swap(2'b01);
    repeat (20) beat({PA, PB}, {PB, PA}, 1'b1, 1'b0);
    idle(4);
    check("swap_q1", q1_o[15:0], PA);
    check("swap_q2", q2_o[15:0], PB);
    check("swap_lock", Lock_o, 2'b11);

    set_swap(2'b00);
    set_mode(2'b10);
    base[0] = 16'hFFF0;
    base[1] = 16'($urandom);
    repeat (24) gen_beat(2'b00, 1'b0);
    idle(4);
    check("ramp_lock", Lock_o, 2'b11);
    gen_beat(2'b01, 1'b0);
    repeat (6) gen_beat(2'b00, 1'b0);
    idle(4);
    check("skip_lock", Lock_o, 2'b11);
    check("skip_err0", ErrCnt_o[3:0], 1);

    for (int blk = 0; blk < 8; blk++) begin
      set_mode(2'($urandom_range(3)));
      set_swap(2'($urandom_range(3)));
      for (int c = 0; c < N; c++) base[c] = 16'($urandom);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(7) == 0)
          beat($urandom, $urandom, 1'b0, 1'b0);
        else
          gen_beat({$urandom_range(7) == 0, $urandom_range(7) == 0},
                   $urandom_range(15) == 0);
      end
    end
    idle(4);
    check("hold_q1", q1_o, last_q1);

    set_mode(2'b01);
    set_swap(2'b00);
    for (int k = 0; k < 6; k++) begin
      repeat (16) beat(pr, pf, 1'b1, 1'b0);
      repeat (4) beat({PA, 16'h0000}, pf, 1'b1, 1'b0);
    end
    idle(4);
    check("sat_err0", ErrCnt_o[3:0], 15);
    repeat (16) beat(pr, pf, 1'b1, 1'b0);
    beat({PA, 16'h0000}, pf, 1'b1, 1'b1);
    repeat (3) beat(pr, pf, 1'b1, 1'b0);
    idle(4);
    check("clr_err0", ErrCnt_o[3:0], 0);
    check("pre_rst_lock0", Lock_o[0], 1);

    do_reset();
    check("mid_rst_lock", Lock_o, 0);
    check("mid_rst_err", ErrCnt_o, 0);
    check("mid_rst_vld", OutVld_o, 0);

    idle(4);
    check("queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
